// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and payload layout for the execute/memory pipeline boundary.
package ex_mem_pipe_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;
    localparam int unsigned CTL_W  = 7;

    // Control bit positions; in_ctl packs {brchcnd, alujmp, mem_en, mem_wr, setrd, reg_we, halt}.
    localparam int unsigned CTL_HALT    = 0;
    localparam int unsigned CTL_REG_WE  = 1;
    localparam int unsigned CTL_SETRD   = 2;
    localparam int unsigned CTL_MEM_WR  = 3;
    localparam int unsigned CTL_MEM_EN  = 4;
    localparam int unsigned CTL_ALUJMP  = 5;
    localparam int unsigned CTL_BRCHCND = 6;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sdata;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] joff;
        logic [CTL_W-1:0]  ctl;
        logic [REG_W-1:0]  wreg;
    } ex_mem_t;

    localparam int unsigned PAYLOAD_W = $bits(ex_mem_t);

    function automatic logic is_load(input logic [CTL_W-1:0] ctl);
        return ctl[CTL_MEM_EN] & ~ctl[CTL_MEM_WR];
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry valid/ready skid buffer with registered upstream ready.
// Main entry drives the output; the skid entry absorbs one beat while ready is being withdrawn.
module pipe_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_block_nxt,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_m_valid;
    logic             r_s_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;

    logic w_accept;
    logic w_fire;
    logic w_m_valid_nxt;
    logic w_s_valid_nxt;
    logic w_m_load_s;
    logic w_m_load_in;
    logic w_s_load_in;
    logic w_ready_nxt;

    assign w_accept = i_valid & r_ready;
    assign w_fire   = r_m_valid & i_ready;

    // Next-state for the two entries; flush kills both, but a beat firing this cycle still leaves.
    always_comb begin
        w_m_valid_nxt = r_m_valid;
        w_s_valid_nxt = r_s_valid;
        w_m_load_s    = 1'b0;
        w_m_load_in   = 1'b0;
        w_s_load_in   = 1'b0;

        if (i_flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
        end else if (!r_m_valid || w_fire) begin
            if (r_s_valid) begin
                w_m_load_s    = 1'b1;
                w_m_valid_nxt = 1'b1;
                w_s_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_m_load_in   = 1'b1;
                w_m_valid_nxt = 1'b1;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_s_load_in   = 1'b1;
            w_s_valid_nxt = 1'b1;
        end

        w_ready_nxt = ~w_s_valid_nxt & ~i_block_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_m_valid <= w_m_valid_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    // Payload storage carries no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (w_m_load_s) begin
            r_m_data <= r_s_data;
        end else if (w_m_load_in) begin
            r_m_data <= i_data;
        end
        if (w_s_load_in) begin
            r_s_data <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_m_valid;
    assign o_data  = r_m_data;

    a_no_skid_overrun: assert property (@(posedge clk) disable iff (!rst_n) w_accept |-> !r_s_valid);

endmodule

// File: rtl/ex_mem_pipe.sv
// Execute-to-memory pipeline register: skid-buffered handshake plus flush,
// halt latching with createdump, and forwarding/load-hazard taps.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_joff,
    input  logic [CTL_W-1:0]  in_ctl,
    input  logic [REG_W-1:0]  in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_sdata,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_joff,
    output logic [CTL_W-1:0]  out_ctl,
    output logic [REG_W-1:0]  out_wreg,
    input  logic              flush,
    output logic              createdump,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              load_busy,
    output logic [REG_W-1:0]  load_reg
);

    ex_mem_t w_in_pl;
    ex_mem_t w_out_pl;

    logic r_halted;
    logic r_halt_pend;
    logic w_halted_nxt;
    logic w_halt_pend_nxt;
    logic w_accept;
    logic w_fire;
    logic w_fire_halt;
    logic w_out_load;

    assign w_in_pl.alu   = in_alu;
    assign w_in_pl.sdata = in_sdata;
    assign w_in_pl.pc    = in_pc;
    assign w_in_pl.joff  = in_joff;
    assign w_in_pl.ctl   = in_ctl;
    assign w_in_pl.wreg  = in_wreg;

    pipe_skid_reg #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst),
        .i_flush     (flush),
        .i_block_nxt (w_halted_nxt),
        .i_valid     (in_valid),
        .o_ready     (in_ready),
        .i_data      (w_in_pl),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (w_out_pl)
    );

    assign w_accept    = in_valid & in_ready;
    assign w_fire      = out_valid & out_ready;
    assign w_fire_halt = w_fire & w_out_pl.ctl[CTL_HALT];

    // Halt bookkeeping: r_halt_pend marks a halt still inside the buffer, so a flush
    // only releases the halt when it actually kills that entry.
    always_comb begin
        w_halted_nxt    = r_halted;
        w_halt_pend_nxt = r_halt_pend;

        if (w_fire_halt) begin
            w_halt_pend_nxt = 1'b0;
        end

        if (flush) begin
            if (r_halt_pend && !w_fire_halt) begin
                w_halted_nxt = 1'b0;
            end
            w_halt_pend_nxt = 1'b0;
        end else if (w_accept && in_ctl[CTL_HALT]) begin
            w_halted_nxt    = 1'b1;
            w_halt_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted    <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_halted    <= w_halted_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    assign out_alu   = w_out_pl.alu;
    assign out_sdata = w_out_pl.sdata;
    assign out_pc    = w_out_pl.pc;
    assign out_joff  = w_out_pl.joff;
    assign out_ctl   = w_out_pl.ctl;
    assign out_wreg  = w_out_pl.wreg;

    assign createdump = w_fire_halt;

    // Hazard taps: loads must stall consumers, everything else writing a register can forward.
    assign w_out_load = is_load(w_out_pl.ctl);
    assign fwd_valid  = out_valid & w_out_pl.ctl[CTL_REG_WE] & ~w_out_load;
    assign load_busy  = out_valid & w_out_pl.ctl[CTL_REG_WE] & w_out_load;
    assign fwd_reg    = w_out_pl.wreg;
    assign load_reg   = w_out_pl.wreg;
    assign fwd_data   = w_out_pl.alu;

    a_halt_blocks: assert property (@(posedge clk) disable iff (!rst) r_halted |-> !in_ready);
    a_dump_valid:  assert property (@(posedge clk) disable iff (!rst) createdump |-> out_valid);

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: scoreboard on every output beat plus
// table-driven tap checks and hand-written flush/halt/reset sequences.
module tb_ex_mem_pipe;
    import ex_mem_pipe_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu, in_sdata, in_pc, in_joff;
    logic [CTL_W-1:0]  in_ctl;
    logic [REG_W-1:0]  in_wreg;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu, out_sdata, out_pc, out_joff;
    logic [CTL_W-1:0]  out_ctl;
    logic [REG_W-1:0]  out_wreg;
    logic              flush;
    logic              createdump;
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_reg;
    logic [DATA_W-1:0] fwd_data;
    logic              load_busy;
    logic [REG_W-1:0]  load_reg;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_sdata(in_sdata), .in_pc(in_pc), .in_joff(in_joff),
        .in_ctl(in_ctl), .in_wreg(in_wreg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_sdata(out_sdata), .out_pc(out_pc), .out_joff(out_joff),
        .out_ctl(out_ctl), .out_wreg(out_wreg),
        .flush(flush), .createdump(createdump),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
        .load_busy(load_busy), .load_reg(load_reg)
    );

    typedef struct {
        logic [DATA_W-1:0] alu;
        logic [CTL_W-1:0]  ctl;
        logic [REG_W-1:0]  wreg;
        logic              exp_fwd;
        logic              exp_load;
    } vec_t;

    localparam logic [CTL_W-1:0] C_RWE  = 7'b0000010;
    localparam logic [CTL_W-1:0] C_HALT = 7'b0000001;

    ex_mem_t sb_q[$];
    ex_mem_t exp_p;
    int      n_tests = 0;
    int      n_fail  = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_p(input string name, input ex_mem_t act, input ex_mem_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got alu=%h sd=%h pc=%h joff=%h ctl=%b wreg=%0d expected alu=%h sd=%h pc=%h joff=%h ctl=%b wreg=%0d",
                     name, act.alu, act.sdata, act.pc, act.joff, act.ctl, act.wreg,
                     exp.alu, exp.sdata, exp.pc, exp.joff, exp.ctl, exp.wreg);
        end
    endtask

    function automatic ex_mem_t mk(input logic [DATA_W-1:0] alu, input logic [CTL_W-1:0] ctl,
                                   input logic [REG_W-1:0] wreg);
        ex_mem_t p;
        p.alu   = alu;
        p.sdata = alu ^ 16'hffff;
        p.pc    = alu + 16'd2;
        p.joff  = {alu[7:0], alu[15:8]};
        p.ctl   = ctl;
        p.wreg  = wreg;
        return p;
    endfunction

    task automatic set_in(input ex_mem_t p);
        in_alu   = p.alu;
        in_sdata = p.sdata;
        in_pc    = p.pc;
        in_joff  = p.joff;
        in_ctl   = p.ctl;
        in_wreg  = p.wreg;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded); returns just after the accepting edge.
    task automatic send(input ex_mem_t p);
        set_in(p);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk_b("send_accept", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
    endtask

    // Scoreboard: push on accept, pop and compare on fire, drop killed entries on flush.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got alu=0x%0h expected no output beat", out_alu);
                end else begin
                    exp_p = sb_q.pop_front();
                    chk_p("payload", {out_alu, out_sdata, out_pc, out_joff, out_ctl, out_wreg}, exp_p);
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back({in_alu, in_sdata, in_pc, in_joff, in_ctl, in_wreg});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{16'h0101, 7'b0000010, 3'd1, 1'b1, 1'b0};
        vecs[1] = '{16'h2002, 7'b0010010, 3'd5, 1'b0, 1'b1};
        vecs[2] = '{16'h3003, 7'b0011000, 3'd2, 1'b0, 1'b0};
        vecs[3] = '{16'h4004, 7'b0000110, 3'd7, 1'b1, 1'b0};
        vecs[4] = '{16'h5005, 7'b1000000, 3'd4, 1'b0, 1'b0};
        vecs[5] = '{16'h6006, 7'b0011010, 3'd6, 1'b1, 1'b0};
        vecs[6] = '{16'h7007, 7'b0010000, 3'd3, 1'b0, 1'b0};
        vecs[7] = '{16'h8008, 7'b0100010, 3'd7, 1'b1, 1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        set_in(mk(16'h0, 7'b0, 3'd0));
        #2;
        chk_b("rst_out_valid", out_valid, 1'b0);
        chk_b("rst_in_ready", in_ready, 1'b0);
        chk_b("rst_createdump", createdump, 1'b0);
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk_b("post_rst_in_ready", in_ready, 1'b1);
        chk_b("post_rst_out_valid", out_valid, 1'b0);
        tick;

        // Single ALU write flows through in one cycle
        out_ready = 1'b1;
        set_in(mk(16'h1234, C_RWE, 3'd3));
        in_valid = 1'b1;
        @(negedge clk);
        chk_b("t1_in_ready", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        @(negedge clk);
        chk_b("t1_out_valid", out_valid, 1'b1);
        chk_w("t1_out_alu", out_alu, 16'h1234);
        chk_b("t1_fwd_valid", fwd_valid, 1'b1);
        chk_w("t1_fwd_reg", 16'(fwd_reg), 16'd3);
        chk_b("t1_in_ready_hold", in_ready, 1'b1);
        tick;

        // Forwarding / load-hazard taps from the vector table
        foreach (vecs[i]) begin
            send(mk(vecs[i].alu, vecs[i].ctl, vecs[i].wreg));
            @(negedge clk);
            chk_b("tbl_out_valid", out_valid, 1'b1);
            chk_b("tbl_fwd_valid", fwd_valid, vecs[i].exp_fwd);
            chk_b("tbl_load_busy", load_busy, vecs[i].exp_load);
            chk_w("tbl_fwd_reg", 16'(fwd_reg), 16'(vecs[i].wreg));
            chk_w("tbl_load_reg", 16'(load_reg), 16'(vecs[i].wreg));
            chk_w("tbl_fwd_data", fwd_data, vecs[i].alu);
            tick;
        end

        // Back-to-back A,B,C with downstream stalled, then drain in order
        out_ready = 1'b0;
        send(mk(16'hA00A, C_RWE, 3'd1));
        send(mk(16'hB00B, C_RWE, 3'd2));
        set_in(mk(16'hC00C, C_RWE, 3'd3));
        in_valid = 1'b1;
        @(negedge clk);
        chk_b("t2_in_ready_full", in_ready, 1'b0);
        chk_w("t2_head", out_alu, 16'hA00A);
        tick;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk_b("t2_c_accept", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        chk_w("t2_drained", 16'(sb_q.size()), 16'd0);
        chk_b("t2_in_ready_back", in_ready, 1'b1);

        // Flush with M and S full and an input presented
        out_ready = 1'b0;
        send(mk(16'hD00D, C_RWE, 3'd4));
        send(mk(16'hE00E, C_RWE, 3'd5));
        set_in(mk(16'hF00F, C_RWE, 3'd6));
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk_b("t3_full", in_ready, 1'b0);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_b("t3_out_valid", out_valid, 1'b0);
        chk_b("t3_in_ready", in_ready, 1'b1);
        tick;
        out_ready = 1'b1;
        repeat (3) tick;

        // Flush discards an input accepted in the same cycle
        out_ready = 1'b0;
        send(mk(16'h1111, C_RWE, 3'd1));
        set_in(mk(16'h2222, C_RWE, 3'd2));
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk_b("t3b_accepting", in_ready, 1'b1);
        tick;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_b("t3b_discard", out_valid, 1'b0);
        tick;
        out_ready = 1'b1;
        repeat (3) tick;

        // Flush while the head fires: the head completes, the skid entry dies
        out_ready = 1'b0;
        send(mk(16'h3333, C_RWE, 3'd3));
        send(mk(16'h4444, C_RWE, 3'd4));
        out_ready = 1'b1;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        @(negedge clk);
        chk_b("t3c_out_valid", out_valid, 1'b0);
        chk_b("t3c_in_ready", in_ready, 1'b1);
        tick;

        // Halt: blocks input, createdump pulses once when it fires
        out_ready = 1'b0;
        send(mk(16'h4A17, C_HALT, 3'd0));
        @(negedge clk);
        chk_b("halt_blocks", in_ready, 1'b0);
        chk_b("halt_no_dump_stalled", createdump, 1'b0);
        tick;
        out_ready = 1'b1;
        @(negedge clk);
        chk_b("halt_dump", createdump, 1'b1);
        tick;
        set_in(mk(16'h5555, C_RWE, 3'd5));
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_b("halt_dump_once", createdump, 1'b0);
            chk_b("halt_stays", in_ready, 1'b0);
            tick;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;

        // Halt flushed in its acceptance cycle never latches
        out_ready = 1'b1;
        set_in(mk(16'h6A17, C_HALT, 3'd0));
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk_b("hf_accepting", in_ready, 1'b1);
        tick;
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk_b("hf_in_ready", in_ready, 1'b1);
        chk_b("hf_out_valid", out_valid, 1'b0);
        chk_b("hf_no_dump", createdump, 1'b0);
        tick;

        // Halt sitting in M killed by flush releases in_ready
        out_ready = 1'b0;
        send(mk(16'h7A17, C_HALT, 3'd0));
        @(negedge clk);
        chk_b("hk_blocked", in_ready, 1'b0);
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        @(negedge clk);
        chk_b("hk_in_ready", in_ready, 1'b1);
        chk_b("hk_out_valid", out_valid, 1'b0);
        chk_b("hk_no_dump", createdump, 1'b0);
        tick;
        out_ready = 1'b1;
        send(mk(16'h7777, C_RWE, 3'd7));
        repeat (2) tick;

        // Asynchronous reset mid-stall with both entries full
        out_ready = 1'b0;
        send(mk(16'h8888, C_RWE, 3'd1));
        send(mk(16'h9999, C_RWE, 3'd2));
        @(negedge clk);
        chk_b("ar_full", in_ready, 1'b0);
        chk_b("ar_valid", out_valid, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        sb_q.delete();
        #1;
        chk_b("ar_out_valid_async", out_valid, 1'b0);
        chk_b("ar_in_ready_async", in_ready, 1'b0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        @(negedge clk);
        chk_b("ar_in_ready_after", in_ready, 1'b1);
        chk_b("ar_no_stale", out_valid, 1'b0);
        tick;
        out_ready = 1'b1;
        repeat (4) tick;
        chk_b("ar_still_empty", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Pipeline boundary between the execute stage and the memory stage of the 16-bit processor. It carries one instruction's execute results (ALU result/address, store data, next PC, branch offset and control bits) into the memory stage under a valid/ready handshake. A two-entry skid buffer keeps the upstream ready signal registered. It also provides flush on taken branch/jump, halt latching with the createdump pulse, and forwarding/load-hazard taps for the hazard unit.

Parameters:
DATA_W, 16, datapath width (ALU result, store data, PC, offset)
REG_W, 3, register specifier width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  block can accept this cycle (registered)
in_alu  in  DATA_W  ALU result / memory address
in_sdata  in  DATA_W  store data
in_pc  in  DATA_W  PC+2 of instruction
in_joff  in  DATA_W  branch/jump offset
in_ctl  in  7  {brchcnd, alujmp, mem_en, mem_wr, setrd, reg_we, halt}
in_wreg  in  REG_W  destination register
out_valid  out  1  memory stage has an instruction
out_ready  in  1  memory stage consumes this cycle
out_alu, out_sdata, out_pc, out_joff  out  DATA_W  registered payload
out_ctl  out  7  registered control, same packing
out_wreg  out  REG_W  registered destination
flush  in  1  taken branch/jump resolved in memory stage; kill younger entries
createdump  out  1  one-cycle pulse when halt instruction fires at output
fwd_valid  out  1  output entry is a non-load register write
fwd_reg  out  REG_W  forwarding destination
fwd_data  out  DATA_W  forwarding value (= out_alu)
load_busy  out  1  output entry is a load with reg_we
load_reg  out  REG_W  destination of that load

Behaviour:
- Storage: main entry M (drives out_*) and skid entry S, each with a valid bit.
- accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = !S.valid & !halted, registered; 1 after reset.
- Per cycle, without flush:
  - M empty or firing: M loads S if S.valid (S cleared), else loads the input if accept, else M.valid <= 0.
  - M valid and not firing: on accept, S loads the input.
  - accept when S.valid is impossible by construction.
- Order is strictly preserved; no entry is dropped or duplicated.
- Latency: 1 cycle input to output when the pipeline flows. Full throughput with out_ready held high.
- flush (synchronous):
  - next cycle M.valid = S.valid = 0.
  - An input accepted in the flush cycle is discarded.
  - A fire in the flush cycle completes normally; it is the branch itself.
  - in_ready = 1 next cycle unless halted.
- halted:
  - set when an entry with halt=1 is accepted and not flushed that cycle.
  - cleared by a flush that kills that halt entry.
  - while set, in_ready = 0.
- createdump = fire & out_ctl.halt, combinational on output registers.
- fwd_valid = out_valid & reg_we & !(mem_en & !mem_wr); load_busy = out_valid & reg_we & mem_en & !mem_wr.
- fwd_reg = load_reg = out_wreg.
- Payload registers need no reset. All valid bits and halted reset to 0.
- While rst low: out_valid = 0, in_ready = 0. Reset mid-operation discards all entries immediately (asynchronous).
- Simultaneous flush and reset: reset dominates.

Decomposition:
- Shared package: ctl bit indices (CTL_BRCHCND..CTL_HALT), CTL_W = 7, payload struct/width constant.
- One natural sub-module: pipe_skid_reg, a generic width-parameterised 2-entry valid/ready skid buffer. ex_mem_pipe wraps it and adds flush, halt, createdump and the forwarding taps.

Test Plan:
- Reset, then in_valid=1 with alu=0x1234, wreg=3, reg_we=1, out_ready=1 -> next cycle out_valid=1, out_alu=0x1234, fwd_valid=1, fwd_reg=3; in_ready=1 throughout.
- Back-to-back A,B,C with out_ready=0 from cycle 1 -> A in M, B in S, in_ready=0. Raise out_ready -> outputs A,B,C in order, in_ready back to 1 after S drains.
- Entry in M and entry in S, flush=1 with simultaneous in_valid -> next cycle out_valid=0, in_ready=1. Input never appears at the output.
- Load (mem_en=1, mem_wr=0, reg_we=1, wreg=5) -> load_busy=1, load_reg=5, fwd_valid=0. Store (mem_wr=1, reg_we=0) -> load_busy=0, fwd_valid=0.
- Halt accepted -> in_ready=0 next cycle. When halt fires, createdump=1 for exactly one cycle. Repeat with flush in the acceptance cycle -> halted stays 0, no createdump.
- Drop rst mid-stall with M and S full -> out_valid=0 and in_ready=0 asynchronously. After rst release, in_ready=1 and no stale entry emerges.
